// File: rtl/noc_pkg.sv
// Shared definitions for the PE-side NoC endpoint: flit field widths, the
// destination-field extractor and the saturating counter step.
package noc_pkg;

    localparam int unsigned NOC_DATA_W = 36;
    localparam int unsigned NOC_ADDR_W = 4;
    localparam int unsigned MAX_FLIT_W = 64;
    localparam int unsigned MAX_ADDR_W = 16;
    localparam int unsigned MAX_CNT_W  = 32;

    // Destination field is the top addr_w bits of a data_w-bit flit.
    function automatic logic [MAX_ADDR_W-1:0] flit_dest(input logic [MAX_FLIT_W-1:0] flit,
                                                        input int unsigned data_w,
                                                        input int unsigned addr_w);
        logic [MAX_FLIT_W-1:0] shifted;
        shifted = (flit >> (data_w - addr_w)) & ((MAX_FLIT_W'(1) << addr_w) - MAX_FLIT_W'(1));
        return shifted[MAX_ADDR_W-1:0];
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                     input int unsigned width);
        logic [MAX_CNT_W-1:0] limit;
        limit = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
        return (value >= limit) ? limit : value + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with registered full/empty flags presented as
// valid/ready on both sides; storage is not reset, only the pointers are.
module noc_flit_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic [PtrW:0]    count_next;
    logic             push;
    logic             pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are computed from the post-edge occupancy, so a read while full
    // only reopens the input on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            in_ready  <= (count_next != (PtrW+1)'(Depth));
            out_valid <= (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    assign out_data = mem[rd_ptr];

endmodule

// File: rtl/noc_pe_endpoint.sv
// PE-side network interface: TX skid FIFO toward the switch, address-filtered
// RX FIFO toward the PE, and saturating tx/rx/drop statistics.
module noc_pe_endpoint
    import noc_pkg::*;
#(
    parameter int unsigned DataWidth = NOC_DATA_W,
    parameter int unsigned AddrWidth = NOC_ADDR_W,
    parameter int unsigned MyAddr    = 0,
    parameter int unsigned RxDepth   = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                           i_mclk,
    input  logic                           i_resetn,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DataWidth-1:0]           o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic [DataWidth-1:0]           i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_rx_data,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    input  logic                           i_stat_clr,
    output logic [CntWidth-1:0]            o_tx_cnt,
    output logic [CntWidth-1:0]            o_rx_cnt,
    output logic [CntWidth-1:0]            o_drop_cnt
);

    localparam int unsigned PayW = DataWidth - AddrWidth;

    logic                addr_match;
    logic                rx_accept;
    logic [2:0]          cnt_inc;
    logic [CntWidth-1:0] cnt [3];

    noc_flit_fifo #(.Width(DataWidth), .Depth(2)) u_tx_fifo (
        .clk       (i_mclk),
        .rst_n     (i_resetn),
        .in_data   ({i_pe_dest, i_pe_data}),
        .in_valid  (i_pe_valid),
        .in_ready  (o_pe_ready),
        .out_data  (o_data),
        .out_valid (o_data_valid),
        .out_ready (i_data_ready)
    );

    assign addr_match = (flit_dest(MAX_FLIT_W'(i_data), DataWidth, AddrWidth)
                         == MAX_ADDR_W'(MyAddr));

    // Misrouted flits are never written, but they still see the FIFO's ready,
    // so a full RX FIFO stalls them too.
    noc_flit_fifo #(.Width(PayW), .Depth(RxDepth)) u_rx_fifo (
        .clk       (i_mclk),
        .rst_n     (i_resetn),
        .in_data   (i_data[PayW-1:0]),
        .in_valid  (i_data_valid & addr_match),
        .in_ready  (o_data_ready),
        .out_data  (o_pe_rx_data),
        .out_valid (o_pe_rx_valid),
        .out_ready (i_pe_rx_ready)
    );

    assign rx_accept = i_data_valid & o_data_ready;
    assign cnt_inc   = {rx_accept & ~addr_match,
                        o_pe_rx_valid & i_pe_rx_ready,
                        o_data_valid & i_data_ready};

    always_ff @(posedge i_mclk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i_stat_clr) begin
                    cnt[i] <= '0;
                end else if (cnt_inc[i]) begin
                    cnt[i] <= CntWidth'(sat_inc(MAX_CNT_W'(cnt[i]), CntWidth));
                end
            end
        end
    end

    assign o_tx_cnt   = cnt[0];
    assign o_rx_cnt   = cnt[1];
    assign o_drop_cnt = cnt[2];

endmodule

// File: tb/tb_noc_pe_endpoint.sv
// Scoreboard bench for noc_pe_endpoint: queue-based reference model, directed
// scenarios followed by randomized traffic with a mid-stream reset.
module tb_noc_pe_endpoint;

    localparam int DW      = 36;
    localparam int AW      = 4;
    localparam int PW      = DW - AW;
    localparam int MY      = 0;
    localparam int RXD     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          i_resetn = 1'b1;
    logic [AW-1:0] i_pe_dest = '0;
    logic [PW-1:0] i_pe_data = '0;
    logic          i_pe_valid = 1'b0;
    logic          o_pe_ready;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          i_data_ready = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_data_valid = 1'b0;
    logic          o_data_ready;
    logic [PW-1:0] o_pe_rx_data;
    logic          o_pe_rx_valid;
    logic          i_pe_rx_ready = 1'b0;
    logic          i_stat_clr = 1'b0;
    logic [CW-1:0] o_tx_cnt;
    logic [CW-1:0] o_rx_cnt;
    logic [CW-1:0] o_drop_cnt;

    noc_pe_endpoint #(
        .DataWidth(DW), .AddrWidth(AW), .MyAddr(MY), .RxDepth(RXD), .CntWidth(CW)
    ) dut (
        .i_mclk        (clk),
        .i_resetn      (i_resetn),
        .i_pe_dest     (i_pe_dest),
        .i_pe_data     (i_pe_data),
        .i_pe_valid    (i_pe_valid),
        .o_pe_ready    (o_pe_ready),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
        .i_data        (i_data),
        .i_data_valid  (i_data_valid),
        .o_data_ready  (o_data_ready),
        .o_pe_rx_data  (o_pe_rx_data),
        .o_pe_rx_valid (o_pe_rx_valid),
        .i_pe_rx_ready (i_pe_rx_ready),
        .i_stat_clr    (i_stat_clr),
        .o_tx_cnt      (o_tx_cnt),
        .o_rx_cnt      (o_rx_cnt),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: flits in flight per direction and the three statistics.
    logic [DW-1:0] tx_q[$];
    logic [PW-1:0] rx_q[$];
    int            m_tx = 0;
    int            m_rx = 0;
    int            m_drop = 0;
    logic [DW-1:0] exp_t;
    logic [PW-1:0] exp_r;

    // Pending stimulus, consumed by the driver.
    logic [DW-1:0] tx_stim[$];
    logic [DW-1:0] rx_stim[$];
    bit mon_en = 0, drv_en = 0, rand_ready = 0, gaps = 0, rand_clr = 0;
    bit tx_fire = 0, rx_fire = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Monitor: sampled mid-cycle; anything seen here transfers on the next rising edge.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("pe_ready",   64'(o_pe_ready),    64'(tx_q.size() < 2));
            check("data_valid", 64'(o_data_valid),  64'(tx_q.size() != 0));
            check("data_ready", 64'(o_data_ready),  64'(rx_q.size() < RXD));
            check("rx_valid",   64'(o_pe_rx_valid), 64'(rx_q.size() != 0));
            check("tx_cnt",     64'(o_tx_cnt),      64'(m_tx));
            check("rx_cnt",     64'(o_rx_cnt),      64'(m_rx));
            check("drop_cnt",   64'(o_drop_cnt),    64'(m_drop));
            if (o_data_valid && i_data_ready) begin
                if (tx_q.size() != 0) begin
                    exp_t = tx_q.pop_front();
                    check("tx_flit", 64'(o_data), 64'(exp_t));
                end
                m_tx = sat(m_tx);
            end
            if (o_pe_rx_valid && i_pe_rx_ready) begin
                if (rx_q.size() != 0) begin
                    exp_r = rx_q.pop_front();
                    check("rx_payload", 64'(o_pe_rx_data), 64'(exp_r));
                end
                m_rx = sat(m_rx);
            end
            if (i_pe_valid && o_pe_ready) tx_q.push_back({i_pe_dest, i_pe_data});
            if (i_data_valid && o_data_ready) begin
                if (i_data[DW-1 -: AW] == AW'(MY)) rx_q.push_back(i_data[PW-1:0]);
                else m_drop = sat(m_drop);
            end
            if (i_stat_clr) begin
                m_tx = 0; m_rx = 0; m_drop = 0;
            end
        end
    end

    // Driver: holds each flit until it has been taken, then presents the next.
    initial forever begin
        @(negedge clk);
        tx_fire = i_pe_valid && o_pe_ready;
        rx_fire = i_data_valid && o_data_ready;
        @(posedge clk);
        #1;
        if (drv_en) begin
            if (tx_fire || !i_pe_valid) begin
                if (tx_stim.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    {i_pe_dest, i_pe_data} = tx_stim.pop_front();
                    i_pe_valid = 1'b1;
                end else begin
                    i_pe_valid = 1'b0;
                end
            end
            if (rx_fire || !i_data_valid) begin
                if (rx_stim.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    i_data = rx_stim.pop_front();
                    i_data_valid = 1'b1;
                end else begin
                    i_data_valid = 1'b0;
                end
            end
            if (rand_ready) begin
                i_data_ready  = ($urandom_range(0, 3) != 0);
                i_pe_rx_ready = ($urandom_range(0, 2) != 0);
            end
            if (rand_clr) i_stat_clr = ($urandom_range(0, 40) == 0);
        end
    end

    task automatic do_reset(input string name);
        mon_en = 0;
        drv_en = 0;
        @(posedge clk);
        #3;
        i_resetn = 1'b0;
        #1;
        check({name, "_data_valid"}, 64'(o_data_valid),  64'd0);
        check({name, "_rx_valid"},   64'(o_pe_rx_valid), 64'd0);
        check({name, "_pe_ready"},   64'(o_pe_ready),    64'd0);
        check({name, "_data_ready"}, 64'(o_data_ready),  64'd0);
        check({name, "_tx_cnt"},     64'(o_tx_cnt),      64'd0);
        check({name, "_rx_cnt"},     64'(o_rx_cnt),      64'd0);
        check({name, "_drop_cnt"},   64'(o_drop_cnt),    64'd0);
        tx_q.delete(); rx_q.delete(); tx_stim.delete(); rx_stim.delete();
        m_tx = 0; m_rx = 0; m_drop = 0;
        i_pe_valid = 1'b0; i_data_valid = 1'b0; i_stat_clr = 1'b0;
        @(posedge clk);
        #1;
        i_resetn = 1'b1;
        #1;
        check({name, "_ready_low_at_release"}, 64'({o_pe_ready, o_data_ready}), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_pe_ready_up"},   64'(o_pe_ready),   64'd1);
        check({name, "_data_ready_up"}, 64'(o_data_ready), 64'd1);
        mon_en = 1;
        drv_en = 1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(tx_stim.size() == 0 && rx_stim.size() == 0 && !i_pe_valid && !i_data_valid &&
                 tx_q.size() == 0 && rx_q.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 64'(n < budget), 64'd1);
    endtask

    task automatic stat_clear();
        i_stat_clr = 1'b1;
        @(posedge clk);
        #1;
        i_stat_clr = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] d;
        do_reset("reset");
        check("reset_tx_cnt_after", 64'(o_tx_cnt), 64'd0);

        // TX streaming, dest 3, payloads 0..7
        i_data_ready = 1'b1;
        i_pe_rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) tx_stim.push_back({4'h3, PW'(i)});
        wait_idle("tx_stream", 100);
        check("tx_stream_cnt", 64'(o_tx_cnt), 64'd8);

        // TX backpressure: 3 flits against a stalled switch
        i_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) tx_stim.push_back({4'h3, PW'(i)});
        cycles(6);
        check("bp_pe_ready",  64'(o_pe_ready),   64'd0);
        check("bp_valid",     64'(o_data_valid), 64'd1);
        check("bp_head_flit", 64'(o_data),       {28'd0, 4'h3, 32'd0});
        i_data_ready = 1'b1;
        wait_idle("bp", 100);
        check("bp_tx_cnt", 64'(o_tx_cnt), 64'd11);

        // RX filter: dest 0,5,0
        stat_clear();
        rx_stim.push_back({4'h0, 32'hAAAA_0001});
        rx_stim.push_back({4'h5, 32'hBBBB_0002});
        rx_stim.push_back({4'h0, 32'hCCCC_0003});
        wait_idle("rx_filter", 100);
        check("rx_filter_drop", 64'(o_drop_cnt), 64'd1);
        check("rx_filter_rx",   64'(o_rx_cnt),   64'd2);

        // RX full: 5 local flits with the PE stalled, then a single read
        stat_clear();
        i_pe_rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) rx_stim.push_back({4'h0, PW'(32'h5000 + i)});
        cycles(12);
        check("rxfull_ready_low", 64'(o_data_ready), 64'd0);
        check("rxfull_5th_wait",  64'(i_data_valid), 64'd1);
        i_pe_rx_ready = 1'b1;
        cycles(1);
        i_pe_rx_ready = 1'b0;
        check("rxfull_ready_after_read", 64'(o_data_ready), 64'd1);
        cycles(1);
        check("rxfull_refilled", 64'(o_data_ready), 64'd0);
        i_pe_rx_ready = 1'b1;
        wait_idle("rxfull", 100);
        check("rxfull_rx_cnt", 64'(o_rx_cnt), 64'd5);

        // Counter saturation and clear-beats-increment
        stat_clear();
        for (int i = 0; i < 17; i++) rx_stim.push_back({4'h5, PW'(i)});
        wait_idle("sat", 200);
        check("sat_drop_cnt", 64'(o_drop_cnt), 64'(CNT_MAX));
        i_stat_clr = 1'b1;
        rx_stim.push_back({4'h9, 32'h1234_5678});
        wait_idle("clr_drop", 50);
        i_stat_clr = 1'b0;
        check("clr_drop_cnt", 64'(o_drop_cnt), 64'd0);

        // Randomized traffic with a reset in the middle of it
        rand_ready = 1; gaps = 1; rand_clr = 1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 200; i++) begin
                d = ($urandom_range(0, 1) != 0) ? AW'(MY) : AW'($urandom_range(1, 15));
                rx_stim.push_back({d, PW'($urandom)});
                tx_stim.push_back({AW'($urandom_range(0, 15)), PW'($urandom)});
            end
            if (pass == 0) begin
                cycles(150 + int'($urandom_range(0, 20)));
                do_reset("midreset");
            end else begin
                wait_idle("random", 8000);
            end
        end
        rand_ready = 0; gaps = 0; rand_clr = 0;
        i_stat_clr = 1'b0;
        i_data_ready = 1'b1;
        i_pe_rx_ready = 1'b1;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d miscompares", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
